// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file for pipelined cores.
// Clears itself with a one-register-per-cycle sweep after reset, forwards
// same-cycle write data to the read ports, and tracks in-flight producers
// with a per-register pending (scoreboard) bit.
//
// Ports:
//   clk, resetn             clock (rising edge), synchronous active-low reset
//   wen, waddr, wdata       writeback write port; also clears pending[waddr]
//   raddr1/2 -> rdata1/2    asynchronous read ports
//   busy1/2                 pending-write flag for raddr1/2
//   sb_set, sb_addr         decode marks sb_addr pending
//   test_addr -> test_data  debug read port
//   init_done               high once the clear sweep has finished
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREG     = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data,
    output logic              init_done
);

    // Pointer carries one extra bit so it never wraps during the sweep.
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] NREG_W   = PTR_W'(NREG);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREG - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nx;
    logic               r_init_done;
    logic [NREG-1:0]    r_pend;
    logic [NREG-1:0]    w_pend_nx;
    logic [DATA_W-1:0]  r_rf [NREG];

    logic w_ready;
    logic w_wr_ok;
    logic w_set_ok;

    // Address refers to a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREG_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_ready  = (r_state == ST_READY);
    assign w_wr_ok  = w_ready && wen && addr_ok(waddr);
    assign w_set_ok = w_ready && sb_set && addr_ok(sb_addr);

    // Next-state logic: sweep one register per cycle, then accept traffic.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        case (r_state)
            ST_INIT: begin
                w_ptr_nx = r_ptr + PTR_W'(1);
                if (r_ptr == LAST_PTR) begin
                    w_state_nx = ST_READY;
                end
            end
            ST_READY: begin
                w_ptr_nx = r_ptr;
            end
        endcase
    end

    // State register; init_done is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_INIT;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_init_done <= (w_state_nx == ST_READY);
        end
    end

    // Scoreboard next value: a set in the same cycle as a clear wins.
    always_comb begin
        w_pend_nx = r_pend;
        for (int i = 0; i < int'(NREG); i++) begin
            if (w_set_ok && (sb_addr == ADDR_W'(i))) begin
                w_pend_nx[i] = 1'b1;
            end else if (w_wr_ok && (waddr == ADDR_W'(i))) begin
                w_pend_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nx;
        end
    end

    // Storage: contents survive the reset cycle; the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (r_state == ST_INIT) begin
                r_rf[r_ptr[ADDR_W-1:0]] <= '0;
            end else if (w_wr_ok) begin
                r_rf[waddr] <= wdata;
            end
        end
    end

    // Read with optional same-cycle forwarding of the write port.
    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (w_ready && addr_ok(a)) begin
            if ((BYPASS != 0) && w_wr_ok && (waddr == a)) begin
                v = wdata;
            end else begin
                v = r_rf[a];
            end
        end
        return v;
    endfunction

    // Busy is masked when the producer's result is being forwarded right now,
    // unless a new producer for the same register is issued in that cycle.
    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        logic fwd;
        fwd = (BYPASS != 0) && w_wr_ok && (waddr == a) &&
              !(w_set_ok && (sb_addr == a));
        return w_ready && addr_ok(a) && r_pend[a] && !fwd;
    endfunction

    always_comb begin
        rdata1    = rd_port(raddr1);
        rdata2    = rd_port(raddr2);
        test_data = rd_port(test_addr);
        busy1     = busy_port(raddr1);
        busy2     = busy_port(raddr2);
    end

    assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three instances (bypass, no bypass, 24 registers)
// share one stimulus stream and are compared every cycle with a register
// file model, plus directed checks on the documented scenarios.
module tb_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          sb_set;
    logic [AW-1:0] sb_addr;
    logic [AW-1:0] test_addr;

    logic [DW-1:0] rd1 [3];
    logic [DW-1:0] rd2 [3];
    logic [DW-1:0] td  [3];
    logic          b1  [3];
    logic          b2  [3];
    logic          idn [3];

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREG(32), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
        .busy1(b1[0]), .busy2(b2[0]), .sb_set(sb_set), .sb_addr(sb_addr),
        .test_addr(test_addr), .test_data(td[0]), .init_done(idn[0]));

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREG(32), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
        .busy1(b1[1]), .busy2(b2[1]), .sb_set(sb_set), .sb_addr(sb_addr),
        .test_addr(test_addr), .test_data(td[1]), .init_done(idn[1]));

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREG(24), .ZERO_REG(1), .BYPASS(1)) u_n24 (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
        .busy1(b1[2]), .busy2(b2[2]), .sb_set(sb_set), .sb_addr(sb_addr),
        .test_addr(test_addr), .test_data(td[2]), .init_done(idn[2]));

    // Reference model: one register array, pending set and sweep count per instance.
    int            n_reg [3] = '{32, 32, 24};
    bit            byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] m_rf   [3][32];
    bit            m_pend [3][32];
    bit            m_ready[3];
    int            m_cnt  [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic bit legal(int k, logic [AW-1:0] a);
        return (int'(a) < n_reg[k]) && (a != 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(int k, logic [AW-1:0] a);
        if (!m_ready[k] || !legal(k, a)) return '0;
        if (byp[k] && wen && (waddr == a)) return wdata;
        return m_rf[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [AW-1:0] a);
        if (!m_ready[k] || !legal(k, a)) return 1'b0;
        if (byp[k] && wen && (waddr == a) && !(sb_set && (sb_addr == a))) return 1'b0;
        return m_pend[k][a];
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rdata1[%0d]", k), rd1[k], exp_rd(k, raddr1));
            chk($sformatf("rdata2[%0d]", k), rd2[k], exp_rd(k, raddr2));
            chk($sformatf("test_data[%0d]", k), td[k], exp_rd(k, test_addr));
            chk($sformatf("busy1[%0d]", k), 32'(b1[k]), 32'(exp_busy(k, raddr1)));
            chk($sformatf("busy2[%0d]", k), 32'(b2[k]), 32'(exp_busy(k, raddr2)));
            chk($sformatf("init_done[%0d]", k), 32'(idn[k]), 32'(m_ready[k]));
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!resetn) begin
                m_ready[k] = 1'b0;
                m_cnt[k]   = 0;
                for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
            end else if (!m_ready[k]) begin
                m_rf[k][m_cnt[k]] = '0;
                m_cnt[k]++;
                if (m_cnt[k] == n_reg[k]) m_ready[k] = 1'b1;
            end else begin
                if (wen && legal(k, waddr)) begin
                    m_rf[k][waddr]   = wdata;
                    m_pend[k][waddr] = 1'b0;
                end
                if (sb_set && legal(k, sb_addr)) m_pend[k][sb_addr] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = 1'b0;
        sb_set = 1'b0;
    endtask

    // Count cycles until the bypass instance reports init_done (bounded).
    task automatic wait_ready(string tag);
        int n;
        n = 0;
        while (idn[0] !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        chk(tag, 32'(n), 32'd32);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_ready[k] = 1'b0;
            m_cnt[k]   = 0;
            for (int i = 0; i < 32; i++) begin
                m_rf[k][i]   = '0;
                m_pend[k][i] = 1'b0;
            end
        end
        resetn = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; sb_set = 1'b0; sb_addr = '0; test_addr = '0;

        // Reset, sweep, preload r5, reset again and confirm it is cleared.
        cycle();
        chk_en = 1'b1;
        cycle();
        resetn = 1'b1;
        wait_ready("sweep_first");
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cycle();
        idle(); test_addr = 5'd5;
        #1 chk("preload_r5", td[0], 32'hDEADBEEF);
        resetn = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
        wait_ready("sweep_len");
        for (int a = 0; a < 32; a++) begin
            test_addr = AW'(a);
            #1 chk($sformatf("cleared_r%0d", a), td[0], 32'h0);
            cycle();
        end

        // Write r7: forwarded with bypass, visible a cycle later without.
        raddr1 = 5'd7; wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        #1 chk("byp_same_cycle", rd1[0], 32'h12345678);
        chk("nobyp_same_cycle", rd1[1], 32'h0);
        cycle();
        idle();
        #1 chk("nobyp_next_cycle", rd1[1], 32'h12345678);
        cycle();

        // Register zero: write and scoreboard set are both dropped.
        raddr1 = 5'd0; wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 5'd0;
        repeat (3) begin
            #1 chk("zero_rdata", rd1[0], 32'h0);
            chk("zero_busy", 32'(b1[0]), 32'h0);
            cycle();
        end
        idle();
        #1 chk("zero_busy_after", 32'(b1[0]), 32'h0);
        cycle();

        // Scoreboard on r3.
        raddr2 = 5'd3; sb_set = 1'b1; sb_addr = 5'd3;
        #1 chk("sb_not_yet", 32'(b2[0]), 32'h0);
        cycle();
        idle();
        #1 chk("sb_busy_next", 32'(b2[0]), 32'h1);
        cycle();
        wen = 1'b1; waddr = 5'd3; wdata = 32'h000000A5;
        #1 chk("sb_fwd_busy", 32'(b2[0]), 32'h0);
        chk("sb_fwd_data", rd2[0], 32'h000000A5);
        chk("sb_nobyp_busy", 32'(b2[1]), 32'h1);
        cycle();
        idle();
        #1 chk("sb_cleared", 32'(b2[0]), 32'h0);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h0000005A; sb_set = 1'b1; sb_addr = 5'd3;
        cycle();
        idle();
        #1 chk("sb_set_wins", 32'(b2[0]), 32'h1);
        cycle();

        // Mid-sweep reset with writes attempted during the sweep.
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        repeat (10) cycle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1; wen = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D;
        wait_ready("sweep_restart");
        idle(); test_addr = 5'd4;
        #1 chk("sweep_wen_ignored", td[0], 32'h0);
        cycle();

        // Out-of-range address on the 24-register instance.
        wen = 1'b1; waddr = 5'd30; wdata = 32'h55; sb_set = 1'b1; sb_addr = 5'd30;
        raddr1 = 5'd30; test_addr = 5'd30;
        #1 chk("oor_td_same", td[2], 32'h0);
        chk("oor_busy_same", 32'(b1[2]), 32'h0);
        cycle();
        idle();
        #1 chk("oor_td_next", td[2], 32'h0);
        chk("oor_busy_next", 32'(b1[2]), 32'h0);
        chk("inrange_r30", td[0], 32'h55);
        cycle();

        // Random traffic with occasional reset.
        repeat (400) begin
            resetn    = ($urandom_range(0, 199) != 0);
            wen       = ($urandom_range(0, 1) == 1);
            waddr     = AW'($urandom_range(0, 31));
            wdata     = $urandom;
            sb_set    = ($urandom_range(0, 2) == 0);
            sb_addr   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
            raddr1    = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 31));
            raddr2    = ($urandom_range(0, 2) == 0) ? sb_addr : AW'($urandom_range(0, 31));
            test_addr = AW'($urandom_range(0, 31));
            cycle();
        end
        resetn = 1'b1;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
